// File: rtl/rs_encode_src_arb.sv
// rs_encode_src_arb: round-robin arbiter feeding whole line codewords from several sources
// into one RS encoder, tagging the encoded byte stream with the owning source id.
module rs_encode_src_arb #(
  parameter int NUM_SRCS  = 4,
  parameter int DATA_W    = 256,
  parameter int NUM_LINES = 8,
  parameter int RS_N      = 255,
  parameter int RS_WORD_W = 8,
  parameter int CW_BYTES  = RS_N,
  localparam int ID_W = $clog2(NUM_SRCS),
  localparam int LC_W = $clog2(NUM_LINES + 1),
  localparam int BC_W = (CW_BYTES > 1) ? $clog2(CW_BYTES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRCS-1:0]        src_arb_line_val,
  input  logic [NUM_SRCS*DATA_W-1:0] src_arb_line,
  output logic [NUM_SRCS-1:0]        arb_src_line_rdy,
  output logic                       arb_enc_line_val,
  output logic [DATA_W-1:0]          arb_enc_line,
  input  logic                       enc_arb_line_rdy,
  input  logic                       enc_arb_in_done,
  input  logic                       enc_arb_byte_val,
  input  logic [RS_WORD_W-1:0]       enc_arb_byte,
  output logic                       arb_enc_byte_rdy,
  output logic                       arb_dst_byte_val,
  output logic [RS_WORD_W-1:0]       arb_dst_byte,
  output logic [ID_W-1:0]            arb_dst_src_id,
  input  logic                       dst_arb_byte_rdy
);
  typedef enum logic [1:0] {IDLE, LOCKED, WAIT_DONE} state_t;
  state_t                  state_q, state_d;
  logic [ID_W-1:0]         grant_q, grant_d, rr_q, rr_d, pick;
  logic [ID_W:0]           idx;
  logic                    found;
  logic [LC_W-1:0]         lcnt_q, lcnt_d;
  logic [BC_W-1:0]         bcnt_q, bcnt_d;
  logic [1:0][ID_W-1:0]    fifo_q, fifo_d;
  logic                    wp_q, wp_d, rp_q, rp_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    id_empty, push, pop, byte_hs, line_hs, last_line;
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_SRCS - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + (ID_W + 1)'(k);
      idx = (idx >= (ID_W + 1)'(NUM_SRCS)) ? idx - (ID_W + 1)'(NUM_SRCS) : idx;
      if (src_arb_line_val[idx[ID_W-1:0]]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
  end
  assign id_empty         = (cnt_q == 2'd0);
  assign byte_hs          = enc_arb_byte_val & dst_arb_byte_rdy & ~id_empty;
  assign pop              = byte_hs & (bcnt_q == BC_W'(CW_BYTES - 1));
  // a pop in the same cycle frees the head slot, so a full FIFO can still take a new id
  assign push             = (state_q == IDLE) & found & ((cnt_q != 2'd2) | pop);
  assign arb_dst_byte_val = enc_arb_byte_val & ~id_empty;
  assign arb_enc_byte_rdy = dst_arb_byte_rdy & ~id_empty;
  assign arb_dst_byte     = enc_arb_byte;
  assign arb_dst_src_id   = id_empty ? '0 : fifo_q[rp_q];
  assign last_line        = (lcnt_q == LC_W'(NUM_LINES - 1));
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_d             = rr_q;
    lcnt_d           = lcnt_q;
    arb_src_line_rdy = '0;
    arb_enc_line_val = 1'b0;
    arb_enc_line     = '0;
    line_hs          = 1'b0;
    if (state_q == IDLE) begin
      grant_d = push ? pick : grant_q;
      rr_d    = push ? ((pick == ID_W'(NUM_SRCS - 1)) ? '0 : pick + 1'b1) : rr_q;
      state_d = push ? LOCKED : IDLE;
    end else if (state_q == LOCKED) begin
      arb_enc_line_val          = src_arb_line_val[grant_q];
      arb_enc_line              = src_arb_line[grant_q*DATA_W +: DATA_W];
      arb_src_line_rdy[grant_q] = enc_arb_line_rdy;
      line_hs                   = arb_enc_line_val & enc_arb_line_rdy;
      lcnt_d                    = line_hs ? (last_line ? '0 : lcnt_q + 1'b1) : lcnt_q;
      state_d                   = (line_hs & last_line) ? WAIT_DONE : LOCKED;
    end else begin
      state_d = enc_arb_in_done ? IDLE : state_q;
    end
  end
  always_comb begin
    bcnt_d = byte_hs ? (pop ? '0 : bcnt_q + 1'b1) : bcnt_q;
    fifo_d = fifo_q;
    if (push) fifo_d[wp_q] = pick;
    wp_d   = wp_q ^ push;
    rp_d   = rp_q ^ pop;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      lcnt_q  <= '0;
      bcnt_q  <= '0;
      fifo_q  <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      lcnt_q  <= lcnt_d;
      bcnt_q  <= bcnt_d;
      fifo_q  <= fifo_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/rs_encode_src_arb.md
RS_ENCODE_SRC_ARB -- requirements
Module: rs_encode_src_arb

Interface
REQ-001 Parameter NUM_SRCS, default 4: number of line requesters sharing one encoder; range 2..16.
REQ-002 Parameter DATA_W, default 256: line width in bits.
REQ-003 Parameter NUM_LINES, default 8: lines per codeword input.
REQ-004 Parameter CW_BYTES, default RS_N: encoded bytes per codeword on the output side.
REQ-005 Ports: clk  in  1  clock. One clock; reset is asynchronous and active-low.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 src_arb_line_val  in  NUM_SRCS  per-source line valid.
REQ-008 src_arb_line  in  NUM_SRCS*DATA_W  per-source line; source i occupies bits [i*DATA_W +: DATA_W].
REQ-009 arb_src_line_rdy  out  NUM_SRCS  per-source line ready.
REQ-010 arb_enc_line_val / arb_enc_line / enc_arb_line_rdy  out 1 / out DATA_W / in 1  line stream to the encoder.
REQ-011 enc_arb_in_done  in  1  single-cycle pulse: encoder input side finished the current codeword.
REQ-012 enc_arb_byte_val / enc_arb_byte / arb_enc_byte_rdy  in 1 / in RS_WORD_W / out 1  encoded byte stream from the encoder.
REQ-013 arb_dst_byte_val / arb_dst_byte / arb_dst_src_id / dst_arb_byte_rdy  out 1 / out RS_WORD_W / out $clog2(NUM_SRCS) / in 1  byte stream tagged with owning source.

Function
REQ-014 Input FSM states SHALL be IDLE, LOCKED, WAIT_DONE.
REQ-015 IDLE: when any src_arb_line_val is high and the ID FIFO is not full, grant the first requester at or after rr_ptr (round-robin, wrap NUM_SRCS-1 -> 0), latch grant id, push id into the ID FIFO, set rr_ptr = grant+1 (mod NUM_SRCS), go to LOCKED; grant decision takes one cycle, no line transferred in IDLE.
REQ-016 LOCKED: arb_enc_line_val = src_arb_line_val[grant], arb_enc_line = granted slice, arb_src_line_rdy[grant] = enc_arb_line_rdy; all other rdy bits 0.
REQ-017 Line counter (width $clog2(NUM_LINES+1)) SHALL increment on each val&rdy in LOCKED; on the handshake of line NUM_LINES go to WAIT_DONE and clear counter.
REQ-018 WAIT_DONE: all arb_src_line_rdy = 0, arb_enc_line_val = 0; on enc_arb_in_done go to IDLE.
REQ-019 enc_arb_in_done arriving in any state other than WAIT_DONE SHALL be ignored.
REQ-020 Grant SHALL not change while LOCKED or WAIT_DONE, regardless of other requests or the granted source dropping val.
REQ-021 ID FIFO: depth 2, width $clog2(NUM_SRCS); simultaneous push and pop in one cycle SHALL be allowed, including when full (pop frees the slot the same cycle) and never when empty.
REQ-022 Output path: arb_dst_byte_val = enc_arb_byte_val & ~id_empty; arb_enc_byte_rdy = dst_arb_byte_rdy & ~id_empty; arb_dst_byte = enc_arb_byte; arb_dst_src_id = ID FIFO head; combinational, zero latency.
REQ-023 Byte counter (width $clog2(CW_BYTES)) SHALL increment per output handshake; on handshake with counter = CW_BYTES-1, pop ID FIFO and clear counter.
REQ-024 Bytes arriving while ID FIFO is empty SHALL be held (rdy low), never dropped or mis-tagged.

Reset
REQ-025 Async assertion of rst_n low SHALL immediately force: FSM IDLE, grant 0, rr_ptr 0, line and byte counters 0, ID FIFO empty.
REQ-026 During reset all rdy and val outputs SHALL be 0; arb_dst_src_id = 0; arb_enc_line = 0.
REQ-027 Reset mid-codeword SHALL discard partial state; first grant after release follows REQ-015 from rr_ptr 0.
REQ-028 Deassertion is synchronous to clk.

Verification
REQ-029 Single source: src 2 sends 8 lines, enc rdy always 1 -> grant 2 one cycle after val, 8 consecutive line handshakes, rdy drops, IDLE after in_done pulse.
REQ-030 Round-robin: all 4 sources request continuously, in_done 3 cycles after each 8th line -> grant order 0,1,2,3,0; no source granted twice before others.
REQ-031 Backpressure: enc_arb_line_rdy toggles 1,0 per cycle -> exactly 8 lines forwarded, data bit-exact, line counter never advances on rdy=0.
REQ-032 Output tagging: codewords for src 1 then src 3, dst_arb_byte_rdy random 50% -> first CW_BYTES bytes tagged 1, next CW_BYTES tagged 3, byte order preserved.
REQ-033 ID FIFO full: two codewords input while output rdy held 0 -> third grant withheld until first CW_BYTES-byte pop; simultaneous push/pop keeps count 2.
REQ-034 Reset mid-operation: rst_n low after line 5 of src 1 -> all outputs 0 immediately; after release, src 0 request granted first.
